// File: rtl/cuteriscv_simctrl_pkg.sv
// Shared types and default constants for the simulation control unit.
// No logic of its own.
// Imported by sim_ctrl_unit and its FIFO sub-module.
package cuteriscv_simctrl_pkg;

  // Terminal status reported on the status port.
  typedef enum logic [2:0] {
    STATUS_RUN     = 3'd0,
    STATUS_PASS    = 3'd1,
    STATUS_FAIL    = 3'd2,
    STATUS_TRAP    = 3'd3,
    STATUS_TIMEOUT = 3'd4
  } status_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    FSM_RUN   = 2'd0,
    FSM_DRAIN = 2'd1,
    FSM_DONE  = 2'd2
  } fsm_e;

  // Plain-vector aliases of the FSM states, used for the state flop.
  localparam logic [1:0] ST_RUN   = FSM_RUN;
  localparam logic [1:0] ST_DRAIN = FSM_DRAIN;
  localparam logic [1:0] ST_DONE  = FSM_DONE;

  // Default memory map and terminal PCs of the test firmware.
  localparam logic [31:0] DEF_CONS_BASE   = 32'h9000_0000;
  localparam logic [31:0] DEF_PASS_PC     = 32'h0000_009c;
  localparam logic [31:0] DEF_FAIL_PC     = 32'h0000_00b8;
  localparam logic [31:0] DEF_TRAP_PC     = 32'h0000_00cc;
  localparam logic [31:0] DEF_TIMEOUT_CYC = 32'hFFFF_FFFF;

  // Store address of console channel ch (one 32-bit word per channel).
  function automatic logic [31:0] cons_addr(input logic [31:0] base, input int ch);
    return base + (32'(ch) << 2);
  endfunction

endpackage

// File: rtl/sim_ctrl_fifo.sv
// Byte-wide FIFO, DEPTH entries, one per console channel.
// Latency: a push is visible at the head (empty=0) the cycle after it is written.
// Backpressure: push on full is refused unless a pop happens in the same cycle.
module sim_ctrl_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       io_clk,
  input  logic       io_rstn,
  input  logic       push,
  input  logic [7:0] push_dat,
  input  logic       pop,
  output logic [7:0] pop_dat,
  output logic       full,
  output logic       empty
);
  import cuteriscv_simctrl_pkg::*;

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra MSB so that full and empty are distinguishable
  // when the address bits are equal.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot this push needs, so full+pop still accepts.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointer arithmetic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer flops; reset empties the FIFO regardless of stored contents.
  always_ff @(posedge io_clk or negedge io_rstn) begin
    if (!io_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge io_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/sim_ctrl_unit.sv
// Simulation control: console byte FIFOs per channel + PASS/FAIL/TRAP end-of-test FSM.
// Latency: store -> FIFO 1 cycle; head byte shown combinationally; done 1 cycle after drain.
// Backpressure: cons_valid/ready, grant held while stalled; full FIFO drops (drop_cnt).
// Optional SIM_CTRL_TIMEOUT_EN: RUN-cycle counter forcing DONE with status TIMEOUT.
import cuteriscv_simctrl_pkg::*;

module sim_ctrl_unit #(
  parameter int          NUM_CH      = 2,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] CONS_BASE   = DEF_CONS_BASE,
  parameter logic [31:0] PASS_PC     = DEF_PASS_PC,
  parameter logic [31:0] FAIL_PC     = DEF_FAIL_PC,
  parameter logic [31:0] TRAP_PC     = DEF_TRAP_PC,
  parameter logic [31:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int         CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic           io_clk,
  input  logic           io_rstn,
  input  logic           wvalid,
  input  logic [31:0]    waddr,
  input  logic [31:0]    wdata,
  input  logic           commit_valid,
  input  logic [31:0]    commit_pc,
  output logic           cons_valid,
  output logic [CHW-1:0] cons_ch,
  output logic [7:0]     cons_data,
  input  logic           cons_ready,
  output logic           done,
  output logic [2:0]     status,
  output logic [15:0]    drop_cnt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]     state_q,   state_d;
  logic [2:0]     status_q,  status_d;
  logic [15:0]    drop_q,    drop_d;
  logic           wr_vld_q,  wr_vld_d;
  logic [CHW-1:0] wr_ch_q,   wr_ch_d;
  logic [7:0]     wr_dat_q,  wr_dat_d;
  logic [CHW-1:0] rr_q,      rr_d;
  logic           lock_q,    lock_d;
  logic [CHW-1:0] lock_ch_q, lock_ch_d;

  // Per-channel FIFO wiring
  logic [NUM_CH-1:0] f_push, f_pop, f_full, f_empty;
  logic [7:0]        f_dat [NUM_CH];

  logic           hit;
  logic [CHW-1:0] hit_ch;
  logic           accept;
  logic           drop_evt;
  logic [CHW-1:0] rr_pick;
  logic           rr_any;
  logic [CHW-1:0] grant;
  logic [2:0]     pc_status;
  logic           pc_match;

  // Only the low byte of a store is console data.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // Channel index base+off, wrapping modulo NUM_CH (NUM_CH need not be a power of two).
  function automatic logic [CHW-1:0] ch_wrap(input logic [CHW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CHW'(s);
  endfunction

  // ---------------------------------------------------------------------------
  // Store capture: decode the console window and register the byte for one cycle
  // ---------------------------------------------------------------------------

  // Address decode against each channel's word.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (waddr == cons_addr(CONS_BASE, n)) begin
        hit    = 1'b1;
        hit_ch = CHW'(n);
      end
    end
  end

  // Once the test has finished, console stores are no longer of interest.
  assign accept = wvalid && hit && (state_q != ST_DONE);

  // Pending-push register: the byte lands in its FIFO on the following edge.
  always_comb begin
    wr_vld_d = accept;
    wr_ch_d  = accept ? hit_ch     : wr_ch_q;
    wr_dat_d = accept ? wdata[7:0] : wr_dat_q;
  end

  // ---------------------------------------------------------------------------
  // Channel FIFOs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sim_ctrl_fifo #(
      .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
      .io_clk   (io_clk),
      .io_rstn  (io_rstn),
      .push     (f_push[g]),
      .push_dat (wr_dat_q),
      .pop      (f_pop[g]),
      .pop_dat  (f_dat[g]),
      .full     (f_full[g]),
      .empty    (f_empty[g])
    );
  end

  // Route the pending push and the output pop to their channels.
  always_comb begin
    f_push = '0;
    f_pop  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      f_push[n] = wr_vld_q && (wr_ch_q == CHW'(n));
      f_pop[n]  = cons_valid && cons_ready && (grant == CHW'(n));
    end
  end

  // A push is lost only when its FIFO is full and is not being popped this cycle.
  assign drop_evt = |(f_push & f_full & ~f_pop);

  // Saturating drop counter.
  always_comb begin
    drop_d = drop_q;
    if (drop_evt && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // ---------------------------------------------------------------------------
  // Output arbitration: round-robin, grant frozen while the consumer stalls
  // ---------------------------------------------------------------------------

  // First non-empty channel at or after rr_q (rr_q is the channel after the last grant).
  always_comb begin
    rr_pick = rr_q;
    rr_any  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!f_empty[ch_wrap(rr_q, i)]) begin
        rr_pick = ch_wrap(rr_q, i);
        rr_any  = 1'b1;
      end
    end
  end

  // A locked channel cannot have been popped, so its head byte is still present.
  assign grant      = lock_q ? lock_ch_q : rr_pick;
  assign cons_valid = lock_q || rr_any;
  assign cons_ch    = cons_valid ? grant : '0;
  assign cons_data  = cons_valid ? f_dat[grant] : 8'h00;

  // Lock the grant on a stall; advance the round-robin start on every pop.
  always_comb begin
    lock_d    = cons_valid && !cons_ready;
    lock_ch_d = grant;
    rr_d      = rr_q;
    if (cons_valid && cons_ready) rr_d = ch_wrap(grant, 1);
  end

  // ---------------------------------------------------------------------------
  // End-of-test FSM
  // ---------------------------------------------------------------------------

`ifdef SIM_CTRL_TIMEOUT_EN
  logic [31:0] cyc_q, cyc_d;
  logic        tmo_hit;

  // Count cycles spent in RUN; the limit is reached on the edge that makes it TIMEOUT_CYC.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == ST_RUN) cyc_d = cyc_q + 32'd1;
  end

  assign tmo_hit = (state_q == ST_RUN) && (cyc_d == TIMEOUT_CYC);

  // Run-cycle counter flop.
  always_ff @(posedge io_clk or negedge io_rstn) begin
    if (!io_rstn) cyc_q <= '0;
    else          cyc_q <= cyc_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Classify the retired PC; anything other than a terminal PC maps to RUN.
  always_comb begin
    pc_status = STATUS_RUN;
    if      (commit_pc == PASS_PC) pc_status = STATUS_PASS;
    else if (commit_pc == FAIL_PC) pc_status = STATUS_FAIL;
    else if (commit_pc == TRAP_PC) pc_status = STATUS_TRAP;
    pc_match = commit_valid && (pc_status != STATUS_RUN);
  end

  // RUN -> DRAIN on the first terminal PC (it beats a same-cycle timeout);
  // DRAIN -> DONE once nothing is buffered, pending, or arriving.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    case (state_q)
      ST_RUN: begin
        if (pc_match) begin
          state_d  = ST_DRAIN;
          status_d = pc_status;
        end
`ifdef SIM_CTRL_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d  = ST_DONE;
          status_d = STATUS_TIMEOUT;
        end
`endif
      end
      ST_DRAIN: begin
        if ((&f_empty) && !wr_vld_q && !accept) state_d = ST_DONE;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // All control flops of the top level.
  always_ff @(posedge io_clk or negedge io_rstn) begin
    if (!io_rstn) begin
      state_q   <= ST_RUN;
      status_q  <= STATUS_RUN;
      drop_q    <= '0;
      wr_vld_q  <= 1'b0;
      wr_ch_q   <= '0;
      wr_dat_q  <= '0;
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      drop_q    <= drop_d;
      wr_vld_q  <= wr_vld_d;
      wr_ch_q   <= wr_ch_d;
      wr_dat_q  <= wr_dat_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  assign done     = (state_q == ST_DONE);
  assign status   = status_q;
  assign drop_cnt = drop_q;

endmodule
